// File: rtl/ps2_pkg.sv
// Shared types and sizing helpers for the PS/2 keyboard receive path.
package ps2_pkg;
  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int FRAME_BITS = 11;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_CNT_W  = $clog2(DEF_DEPTH) + 1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead scancode FIFO with push/pop/flush and occupancy count.
module sync_fifo
  import ps2_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver: pin sync, frame FSM with watchdog, scancode FIFO.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2,
  localparam int WW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        rd_stb,
  input  logic                        clr_stb,
  output logic [7:0]                  rd_data,
  output logic                        ready,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        parity_err,
  output logic                        frame_irq
);
  logic [SYNC_STAGES-1:0] sclk_q, sdat_q;
  logic                   prev_q;
  logic                   sclk, sdat, fall;

  state_e        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          ovf_q, ovf_d;
  logic          perr_q, perr_d;
  logic          irq_q;
  logic          good, bad;
  logic          full, empty;

  assign sclk = sclk_q[SYNC_STAGES-1];
  assign sdat = sdat_q[SYNC_STAGES-1];
  assign fall = prev_q & ~sclk;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    good    = 1'b0;
    bad     = 1'b0;
    if (fall) begin
      unique case (state_q)
        IDLE: if (!sdat) begin
          state_d = DATA;
          bcnt_d  = '0;
        end
        DATA: begin
          sh_d   = {sdat, sh_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = sdat;
          state_d = STOP;
        end
        STOP: begin
          good    = sdat & (^{sh_q, par_q});
          bad     = ~good;
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE && wd_q >= WW'(TIMEOUT_CYC)) begin
      state_d = IDLE;
    end
  end

  assign wd_d = fall ? '0
              : (wd_q >= WW'(TIMEOUT_CYC)) ? wd_q
              : wd_q + WW'(1);

  // A set on the same cycle as clr_stb survives the clear.
  assign ovf_d  = (ovf_q & ~clr_stb)
                | (good & full & ~(rd_stb & ~clr_stb));
  assign perr_d = (perr_q & ~clr_stb) | bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q  <= '1;
      sdat_q  <= '1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      wd_q    <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[SYNC_STAGES-2:0], ps2_clk};
      sdat_q  <= {sdat_q[SYNC_STAGES-2:0], ps2_data};
      prev_q  <= sclk;
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      wd_q    <= wd_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
      irq_q   <= good;
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (good),
    .data_i (sh_q),
    .pop_i  (rd_stb),
    .flush_i(clr_stb),
    .data_o (rd_data),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );

  assign ready      = ~empty;
  assign overflow   = ovf_q;
  assign parity_err = perr_q;
  assign frame_irq  = irq_q;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl with a scancode scoreboard queue.
module tb_ps2_kbd_ctrl;
  localparam int DEPTH = 8;
  localparam int TO    = 1000;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_stb = 1'b0;
  logic       clr_stb = 1'b0;
  logic [7:0] rd_data;
  logic       ready;
  logic [3:0] count;
  logic       overflow;
  logic       parity_err;
  logic       frame_irq;

  int         n_cmp = 0;
  int         n_err = 0;
  int         irq_cnt = 0;
  int         exp_irq = 0;
  logic [7:0] exp_q[$];

  ps2_kbd_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(TO),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_stb    (rd_stb),
    .clr_stb   (clr_stb),
    .rd_data   (rd_data),
    .ready     (ready),
    .count     (count),
    .overflow  (overflow),
    .parity_err(parity_err),
    .frame_irq (frame_irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_irq) irq_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input bit badpar);
    return {1'b1, (~^d) ^ badpar, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(HALF);
      ps2_clk = 1'b0;
      if (pop && i == 10) begin
        tick(2);
        rd_stb = 1'b1;
        tick(1);
        rd_stb = 1'b0;
        tick(HALF - 3);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic send_code(input logic [7:0] d, input bit badpar, input bit pop);
    send_bits(frame(d, badpar), 11, pop);
    if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (!badpar) begin
      exp_irq++;
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
    end
  endtask

  task automatic pulse_rd();
    rd_stb = 1'b1;
    tick(1);
    rd_stb = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic pulse_clr();
    clr_stb = 1'b1;
    tick(1);
    clr_stb = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_cmp++;
    if ({ready, count, rd_data} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_fifo: got %0h want 0", {ready, count, rd_data});
    end
    n_cmp++;
    if ({overflow, parity_err, frame_irq} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 000", {overflow, parity_err, frame_irq});
    end
  endtask

  task automatic test_single_frame();
    exp_irq = irq_cnt;
    send_code(8'h1C, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || rd_data !== exp_q[0]) begin
      n_err++;
      $display("FAIL single_head: got rdy=%b %h want 1 %h", ready, rd_data, exp_q[0]);
    end
    n_cmp++;
    if (count !== 4'(exp_q.size())) begin
      n_err++;
      $display("FAIL single_count: got %0d want %0d", count, exp_q.size());
    end
    n_cmp++;
    if (irq_cnt !== exp_irq) begin
      n_err++;
      $display("FAIL single_irq: got %0d want %0d", irq_cnt, exp_irq);
    end
    n_cmp++;
    if ({overflow, parity_err} !== 2'b00) begin
      n_err++;
      $display("FAIL single_flags: got %b want 00", {overflow, parity_err});
    end
  endtask

  task automatic test_fifo_order();
    pulse_clr();
    send_code(8'hF0, 1'b0, 1'b0);
    send_code(8'h1C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ready !== (exp_q.size() > 0)) begin
        n_err++;
        $display("FAIL order_ready[%0d]: got %b want %b", i, ready, exp_q.size() > 0);
      end
      n_cmp++;
      if (rd_data !== (exp_q.size() > 0 ? exp_q[0] : 8'h00)) begin
        n_err++;
        $display("FAIL order_data[%0d]: got %h want %h", i, rd_data,
                 exp_q.size() > 0 ? exp_q[0] : 8'h00);
      end
      pulse_rd();
    end
    @(negedge clk);
    n_cmp++;
    if (count !== 4'd0) begin
      n_err++;
      $display("FAIL order_count: got %0d want 0", count);
    end
  endtask

  task automatic test_parity();
    exp_irq = irq_cnt;
    send_code(8'h1C, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (parity_err !== 1'b1 || count !== 4'(exp_q.size())) begin
      n_err++;
      $display("FAIL parity_set: got perr=%b cnt=%0d want 1 %0d", parity_err, count, exp_q.size());
    end
    n_cmp++;
    if (irq_cnt !== exp_irq) begin
      n_err++;
      $display("FAIL parity_irq: got %0d want %0d", irq_cnt, exp_irq);
    end
    pulse_clr();
    @(negedge clk);
    n_cmp++;
    if (parity_err !== 1'b0) begin
      n_err++;
      $display("FAIL parity_clr: got %b want 0", parity_err);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 1; i++) send_code(8'h30 + 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (count !== 4'(exp_q.size()) || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_full: got cnt=%0d ovf=%b want %0d 1", count, overflow, exp_q.size());
    end
    n_cmp++;
    if (rd_data !== exp_q[0]) begin
      n_err++;
      $display("FAIL ovf_head: got %h want %h", rd_data, exp_q[0]);
    end
    pulse_clr();
    @(negedge clk);
    n_cmp++;
    if (overflow !== 1'b0 || count !== 4'd0) begin
      n_err++;
      $display("FAIL ovf_clr: got ovf=%b cnt=%0d want 0 0", overflow, count);
    end
    for (int i = 0; i < DEPTH; i++) send_code(8'h40 + 8'(i), 1'b0, 1'b0);
    send_code(8'h48, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (count !== 4'(exp_q.size()) || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_pop: got cnt=%0d ovf=%b want %0d 0", count, overflow, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      @(negedge clk);
      n_cmp++;
      if (rd_data !== exp_q[0]) begin
        n_err++;
        $display("FAIL ovf_drain: got %h want %h", rd_data, exp_q[0]);
      end
      pulse_rd();
    end
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_empty: got %b want 0", ready);
    end
  endtask

  task automatic test_timeout();
    send_bits(frame(8'h77, 1'b0), 5, 1'b0);
    tick(TO + 10);
    send_code(8'h29, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (count !== 4'(exp_q.size()) || rd_data !== exp_q[0]) begin
      n_err++;
      $display("FAIL timeout_q: got cnt=%0d %h want %0d %h", count, rd_data, exp_q.size(), exp_q[0]);
    end
    n_cmp++;
    if ({overflow, parity_err} !== 2'b00) begin
      n_err++;
      $display("FAIL timeout_flags: got %b want 00", {overflow, parity_err});
    end
    pulse_rd();
  endtask

  task automatic test_reset_mid();
    send_bits(frame(8'h33, 1'b0), 4, 1'b0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    exp_q.delete();
    send_code(8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (count !== 4'(exp_q.size()) || rd_data !== exp_q[0]) begin
      n_err++;
      $display("FAIL rstmid: got cnt=%0d %h want %0d %h", count, rd_data, exp_q.size(), exp_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fifo_order();
    test_parity();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
